// File: rtl/vga_main.sv
// -----------------------------------------------------------------------------
// vga_main -- 640x480@60 Hz VGA test-pattern generator.
//
// Free-running horizontal (x) and vertical (y) pixel counters produce
// registered, negative-polarity hsync/vsync and 1-bit-per-channel RGB.
// Eight vertical colour bars (white on the left, black on the right) fill the
// visible area; everything outside the visible area is black.
//
// Ports
//   _i_clk    in   1  pixel clock (25.175/25 MHz), rising edge only
//   _i_rst    in   1  synchronous, active-high reset
//   __output  out  5  {hsync, vsync, r, g, b}; bit4 = hsync, bit0 = b
//
// Build option
//   VGA_CHECKER_EN  when defined, visible RGB is XORed with {3{x[5]^y[5]}},
//                   overlaying a 32x32 inverting checkerboard on the bars.
//                   Sync timing is identical in both builds.
//
// Timing parameters default to the 640x480@60 mode; they exist so the same
// logic can be exercised with a shrunken raster.
// -----------------------------------------------------------------------------
module vga_main #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int BAR_WIDTH = 80
) (
  input  logic       _i_clk,
  input  logic       _i_rst,
  output logic [4:0] __output
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [6:0] BAR_LAST = 7'(BAR_WIDTH - 1);

  localparam logic [4:0] OUT_RESET = 5'b11000;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [2:0] bar_q, bar_d;
  logic [6:0] bar_px_q, bar_px_d;
  logic [4:0] out_q, out_d;

  logic       x_wrap_s;
  logic       hsync_s;
  logic       vsync_s;
  logic       visible_s;
  logic [2:0] bars_s;
  logic [2:0] pattern_s;
  logic [2:0] rgb_s;

  // Raster counters: x wraps at the end of a line, y advances on that same edge.
  always_comb begin
    x_wrap_s = (x_q == H_LAST);
    if (x_wrap_s) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
      y_d = y_q;
    end
  end

  // Bar index tracks x / BAR_WIDTH without a divider; both counters restart
  // whenever the next x is 0 so that bar = 0 while x = 0.
  always_comb begin
    if (x_wrap_s) begin
      bar_d    = 3'd0;
      bar_px_d = 7'd0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_d    = bar_q + 3'd1;
      bar_px_d = 7'd0;
    end else begin
      bar_d    = bar_q;
      bar_px_d = bar_px_q + 7'd1;
    end
  end

  // Output decode from the current (pre-increment) counter values.
  always_comb begin
    hsync_s   = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    vsync_s   = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    visible_s = (x_q < H_VIS) && (y_q < V_VIS);
    bars_s    = 3'd7 - bar_q;
`ifdef VGA_CHECKER_EN
    pattern_s = bars_s ^ {3{x_q[5] ^ y_q[5]}};
`else
    pattern_s = bars_s;
`endif
    if (visible_s) begin
      rgb_s = pattern_s;
    end else begin
      rgb_s = 3'b000;
    end
    out_d = {hsync_s, vsync_s, rgb_s};
  end

  // State and output registers; reset wins over any raster position.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      bar_q    <= 3'd0;
      bar_px_q <= 7'd0;
      out_q    <= OUT_RESET;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
      out_q    <= out_d;
    end
  end

  assign __output = out_q;

endmodule

// File: tb/tb_vga_main.sv
// -----------------------------------------------------------------------------
// tb_vga_main -- self-checking bench for vga_main.
//
// u_main runs the real 640x480 raster; u_small runs a shrunken raster so that
// whole frames (vsync position and period, black lines below the visible
// area) fit in a short run. Expected outputs come from ref_out(), which
// derives x, y, bar and colour from the edge count with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_main;

  logic       clk = 1'b0;
  logic       rst_main = 1'b1;
  logic       rst_small = 1'b1;
  logic [4:0] out_main;
  logic [4:0] out_small;

  int n_total = 0;
  int n_bad   = 0;
  int k_main  = 0;

  // Small raster: line = 24 pixels, frame = 13 lines (312 edges).
  localparam int SH_V = 16, SH_F = 2, SH_S = 4, SH_B = 2;
  localparam int SV_V = 6,  SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_BW = 2;

  vga_main u_main (
    ._i_clk   (clk),
    ._i_rst   (rst_main),
    .__output (out_main)
  );

  vga_main #(
    .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
    .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B),
    .BAR_WIDTH (S_BW)
  ) u_small (
    ._i_clk   (clk),
    ._i_rst   (rst_small),
    .__output (out_small)
  );

  always #5 clk = ~clk;

  // Expected output after the k-th edge following reset release (k >= 1).
  function automatic logic [4:0] ref_out(int k, int hv, int hf, int hs, int hb,
                                         int vv, int vf, int vs, int vb, int bw);
    int ht, vt, x, y;
    logic h, v;
    logic [2:0] c;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    x  = (k - 1) % ht;
    y  = ((k - 1) / ht) % vt;
    h  = !((x >= hv + hf) && (x < hv + hf + hs));
    v  = !((y >= vv + vf) && (y < vv + vf + vs));
    if ((x < hv) && (y < vv)) begin
      c = 3'(7 - x / bw);
`ifdef VGA_CHECKER_EN
      if ((((x >> 5) ^ (y >> 5)) & 1) == 1) c = ~c;
`endif
    end else begin
      c = 3'b000;
    end
    return {h, v, c};
  endfunction

  function automatic logic [4:0] main_ref(int k);
    return ref_out(k, 640, 16, 96, 48, 480, 10, 2, 33, 80);
  endfunction

  function automatic logic [4:0] small_ref(int k);
    return ref_out(k, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, S_BW);
  endfunction

  task automatic test_reset();
    rst_main = 1'b1;
    rst_small = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_main !== 5'b11000) begin
        n_bad++;
        $display("FAIL reset_main edge=%0d got=%b want=%b", i, out_main, 5'b11000);
      end
      n_total++;
      if (out_small !== 5'b11000) begin
        n_bad++;
        $display("FAIL reset_small edge=%0d got=%b want=%b", i, out_small, 5'b11000);
      end
    end
  endtask

  // First lines of a frame, down to y=32 (checkerboard row change).
  task automatic test_line_timing();
    logic [2:0] want_rgb;
    logic       chk_rgb;
    rst_main = 1'b0;
    for (int k = 1; k <= 25601; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_main !== main_ref(k)) begin
        n_bad++;
        $display("FAIL line k=%0d got=%b want=%b", k, out_main, main_ref(k));
      end
      if (k % 800 == 656 || k % 800 == 753) begin
        n_total++;
        if (out_main[4] !== 1'b1) begin
          n_bad++;
          $display("FAIL hsync_high k=%0d got=%b want=1", k, out_main[4]);
        end
      end
      if (k % 800 == 657 || k % 800 == 752) begin
        n_total++;
        if (out_main[4] !== 1'b0) begin
          n_bad++;
          $display("FAIL hsync_low k=%0d got=%b want=0", k, out_main[4]);
        end
      end
      chk_rgb = 1'b1;
`ifdef VGA_CHECKER_EN
      case (k)
        1:       want_rgb = 3'b111;
        33:      want_rgb = 3'b000;
        641:     want_rgb = 3'b000;
        25601:   want_rgb = 3'b000;
        default: chk_rgb = 1'b0;
      endcase
`else
      case (k)
        1:       want_rgb = 3'b111;
        81:      want_rgb = 3'b110;
        561:     want_rgb = 3'b000;
        641:     want_rgb = 3'b000;
        25601:   want_rgb = 3'b111;
        default: chk_rgb = 1'b0;
      endcase
`endif
      if (chk_rgb) begin
        n_total++;
        if (out_main[2:0] !== want_rgb) begin
          n_bad++;
          $display("FAIL colour k=%0d got=%b want=%b", k, out_main[2:0], want_rgb);
        end
      end
    end
    k_main = 25601;
  endtask

  // Run on from the current position, reset for one edge at a random point,
  // then verify the raster restarts from x=0, y=0.
  task automatic test_mid_frame_reset();
    int r;
    r = $urandom_range(8000, 800);
    for (int i = 1; i <= r; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_main !== main_ref(k_main + i)) begin
        n_bad++;
        $display("FAIL pre_reset k=%0d got=%b want=%b", k_main + i, out_main,
                 main_ref(k_main + i));
      end
    end
    rst_main = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (out_main !== 5'b11000) begin
      n_bad++;
      $display("FAIL mid_reset got=%b want=%b", out_main, 5'b11000);
    end
    rst_main = 1'b0;
    for (int k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_main !== main_ref(k)) begin
        n_bad++;
        $display("FAIL restart k=%0d got=%b want=%b", k, out_main, main_ref(k));
      end
      if (k == 1) begin
        n_total++;
        if (out_main[2:0] !== 3'b111) begin
          n_bad++;
          $display("FAIL restart_rgb got=%b want=111", out_main[2:0]);
        end
      end
      if (k == 657) begin
        n_total++;
        if (out_main[4] !== 1'b0) begin
          n_bad++;
          $display("FAIL restart_hsync got=%b want=0", out_main[4]);
        end
      end
    end
    k_main = 1700;
  endtask

  // Whole frames on the shrunken raster: vsync position, width and period.
  task automatic test_small_frame();
    int ht, ft, first_fall, low_cnt, n_fall;
    int falls[$];
    logic prev_v;
    ht = SH_V + SH_F + SH_S + SH_B;
    ft = ht * (SV_V + SV_F + SV_S + SV_B);
    first_fall = (SV_V + SV_F) * ht + 1;
    low_cnt = 0;
    prev_v = 1'b1;
    rst_small = 1'b0;
    for (int k = 1; k <= 3 * ft; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_small !== small_ref(k)) begin
        n_bad++;
        $display("FAIL small k=%0d got=%b want=%b", k, out_small, small_ref(k));
      end
      if (prev_v === 1'b1 && out_small[3] === 1'b0) falls.push_back(k);
      if (k <= ft && out_small[3] === 1'b0) low_cnt++;
      prev_v = out_small[3];
    end
    n_fall = falls.size();
    n_total++;
    if (n_fall != 3) begin
      n_bad++;
      $display("FAIL vsync_fall_count got=%0d want=3", n_fall);
    end
    for (int i = 0; i < n_fall && i < 3; i++) begin
      n_total++;
      if (falls[i] != first_fall + i * ft) begin
        n_bad++;
        $display("FAIL vsync_fall idx=%0d got=%0d want=%0d", i, falls[i],
                 first_fall + i * ft);
      end
    end
    n_total++;
    if (low_cnt != SV_S * ht) begin
      n_bad++;
      $display("FAIL vsync_width got=%0d want=%0d", low_cnt, SV_S * ht);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_mid_frame_reset();
    test_mid_frame_reset();
    test_small_frame();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
